// File: rtl/mem_bus_master_pkg.sv
// Shared bus widths and FSM state type for the memory bus initiator.
package mem_bus_master_pkg;

   localparam int unsigned BUS_ADDR_W = 5;
   localparam int unsigned BUS_DATA_W = 8;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [2:0] {
      IDLE,
      RD_STROBE,
      WR_SETUP,
      WR_STROBE,
      WR_HOLDS,
      TURN
   } state_t;

endpackage

// File: rtl/mem_bus_master_bus_tristate.sv
// Tristate driver for the bidirectional memory data bus.
module bus_tristate
   import mem_bus_master_pkg::*;
#(
   parameter int unsigned DATA_W = BUS_DATA_W
) (
   input  logic              oe,
   input  logic [DATA_W-1:0] dout,
   output logic [DATA_W-1:0] din,
   inout  wire  [DATA_W-1:0] pad
);

   assign pad = oe ? dout : 'z;
   assign din = pad;

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the memory bus: one request at a time, sequences
// read/write strobes and returns read data or a write acknowledge.
module mem_bus_master
   import mem_bus_master_pkg::*;
#(
   parameter int unsigned ADDR_W  = BUS_ADDR_W,
   parameter int unsigned DATA_W  = BUS_DATA_W,
   parameter int unsigned RD_WAIT = 1,
   parameter int unsigned WR_HOLD = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read_en,
   output logic              mem_write_en,
   inout  wire  [DATA_W-1:0] mem_data
);

   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_HOLD - 1);

   state_t             state, state_n;
   logic [CNT_W-1:0]   wait_cnt;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  mem_din;
   logic               data_oe;
   logic               accept;
   logic               rd_en_n, wr_en_n, oe_n, rsp_n;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (req_valid) state_n = req_write ? WR_SETUP : RD_STROBE;
         RD_STROBE: if (wait_cnt == RD_LAST) state_n = TURN;
         WR_SETUP:  state_n = WR_STROBE;
         WR_STROBE: state_n = WR_HOLDS;
         WR_HOLDS:  if (wait_cnt == WR_LAST) state_n = TURN;
         TURN:      state_n = IDLE;
         default:   state_n = IDLE;
      endcase
      // Bus controls are decoded from the next state so they leave a flop
      // aligned with the state they belong to, free of decode glitches.
      rd_en_n = (state_n == RD_STROBE);
      wr_en_n = (state_n == WR_STROBE);
      oe_n    = (state_n inside {WR_SETUP, WR_STROBE, WR_HOLDS});
      rsp_n   = (state_n == TURN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         mem_addr     <= '0;
         wdata_q      <= '0;
         rsp_rdata    <= '0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         data_oe      <= 1'b0;
         rsp_valid    <= 1'b0;
      end else begin
         state        <= state_n;
         wait_cnt     <= (state_n == state && state != IDLE) ? wait_cnt + 1'b1 : '0;
         if (accept) begin
            mem_addr <= req_addr;
            wdata_q  <= req_wdata;
         end
         if (state == RD_STROBE && state_n == TURN) rsp_rdata <= mem_din;
         mem_read_en  <= rd_en_n;
         mem_write_en <= wr_en_n;
         data_oe      <= oe_n;
         rsp_valid    <= rsp_n;
      end
   end

   bus_tristate #(.DATA_W(DATA_W)) u_bus_tristate (
      .oe   (data_oe),
      .dout (wdata_q),
      .din  (mem_din),
      .pad  (mem_data)
   );

endmodule
